// File: rtl/kmkz_ahb_defs.sv
// Shared AHB-Lite encodings and slave FSM states for the uRV data-bus SRAM.
// Also holds the byte-lane and legality decode used in the address phase.
package kmkz_ahb_defs;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

  function automatic logic [3:0] size_be(
    input logic [2:0] size,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (1'b1)
      size == HSIZE_BYTE: be = 4'b0001 << off;
      size == HSIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default:            be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic size_err(
    input logic [2:0] size,
    input logic [1:0] off
  );
    return (size == HSIZE_HALF && off[0])
        || (size == HSIZE_WORD && off != 2'b00)
        || (size > HSIZE_WORD);
  endfunction

endpackage

// File: rtl/urv_sram_be.sv
// Single-port-read, single-port-write 32-bit SRAM with byte enables.
// Read is registered and returns the pre-write contents on a same-edge write.
module urv_sram_be #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/urv_ahb_sram_slave.sv
// AHB-Lite data SRAM slave: wait states, ERROR on bad size/alignment,
// and write-to-read forwarding for back-to-back same-word accesses.
module urv_ahb_sram_slave
  import kmkz_ahb_defs::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [3:0] WS_LOAD =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  slv_state_e    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic          fwd_q, fwd_d;
  logic [3:0]    fwd_be_q, fwd_be_d;
  logic [31:0]   fwd_dat_q, fwd_dat_d;

  logic [AW-1:0] haddr_w;
  logic          accept;
  logic          open_st;
  logic          take;
  logic          req_err;
  logic          commit;
  logic [AW-1:0] ram_raddr;
  logic [31:0]   ram_rdata;
  logic [31:0]   merged;
  logic          unused_in;

  assign haddr_w = HADDR[AW+1:2];
  assign accept  = HSEL && HTRANS[1] && HREADY;
  assign open_st = (state_q == ST_IDLE)
                || (state_q == ST_DATA)
                || (state_q == ST_ERR2);
  assign take    = accept && open_st;
  assign req_err = size_err(HSIZE, HADDR[1:0]);
  assign commit  = !rst_i && (state_q == ST_DATA) && wr_q;

  assign unused_in = ^{HBURST, HPROT, HMASTLOCK, HADDR[31:AW+2]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      fwd_q     <= 1'b0;
      fwd_be_q  <= '0;
      fwd_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      fwd_q     <= fwd_d;
      fwd_be_q  <= fwd_be_d;
      fwd_dat_q <= fwd_dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else cnt_d = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    if (take) begin
      if (req_err) begin
        state_d = ST_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_d = ST_WAIT;
        cnt_d   = WS_LOAD;
      end else begin
        state_d = ST_DATA;
      end
    end
  end

  // The RAM read this edge sees pre-commit data; capture the write to patch it.
  always_comb begin
    wr_d      = wr_q;
    addr_d    = addr_q;
    be_d      = be_q;
    fwd_d     = fwd_q;
    fwd_be_d  = fwd_be_q;
    fwd_dat_d = fwd_dat_q;
    if (take) begin
      wr_d      = HWRITE;
      addr_d    = haddr_w;
      be_d      = size_be(HSIZE, HADDR[1:0]);
      fwd_d     = !HWRITE && commit && (addr_q == haddr_w);
      fwd_be_d  = be_q;
      fwd_dat_d = HWDATA;
    end
  end

  assign ram_raddr = (take && !HWRITE) ? haddr_w : addr_q;

  urv_sram_be #(
    .ADDR_WIDTH(AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (commit),
    .be_i    (be_q),
    .waddr_i (addr_q),
    .wdata_i (HWDATA),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    merged = ram_rdata;
    for (int b = 0; b < 4; b++) begin
      if (fwd_q && fwd_be_q[b]) merged[8*b +: 8] = fwd_dat_q[8*b +: 8];
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    unique case (state_q)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      ST_DATA: begin
        if (!wr_q) HRDATA = merged;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_urv_ahb_sram_slave.sv
// Directed bench for urv_ahb_sram_slave: a zero-wait and a two-wait instance
// share one bus; each sequence checks only the instance it targets.
module tb_urv_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        ro0, rs0, ro2, rs2;
  logic [31:0] rd0, rd2;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  urv_ahb_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(0)) u0 (
    .clk_i(clk), .rst_i(rst), .HSEL(hsel), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
    .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0)
  );

  urv_ahb_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(2)) u2 (
    .clk_i(clk), .rst_i(rst), .HSEL(hsel), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
    .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(ro2), .HRESP(rs2), .HRDATA(rd2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic sel, input logic [1:0] tr,
                     input logic wr, input logic [2:0] sz,
                     input logic [31:0] a, input logic rdy);
    hsel   = sel;
    htrans = tr;
    hwrite = wr;
    hsize  = sz;
    haddr  = a;
    hready = rdy;
  endtask

  task automatic idle(input logic rdy);
    bus(1'b1, 2'b00, 1'b0, 3'd2, 32'h0, rdy);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ws2_write(input logic [31:0] a, input logic [31:0] d);
    bus(1'b1, 2'b10, 1'b1, 3'd2, a, 1'b1);
    tick();
    chk("w2_wait1", 32'(ro2), 32'd0);
    hwdata = d;
    idle(1'b0);
    tick();
    chk("w2_wait2", 32'(ro2), 32'd0);
    tick();
    chk("w2_done", 32'(ro2), 32'd1);
    idle(1'b1);
    tick();
  endtask

  task automatic ws2_read(input logic [31:0] a, input logic [31:0] exp);
    bus(1'b1, 2'b10, 1'b0, 3'd2, a, 1'b1);
    tick();
    chk("r2_wait1", 32'(ro2), 32'd0);
    chk("r2_wait1_data", rd2, 32'h0);
    idle(1'b0);
    tick();
    chk("r2_wait2", 32'(ro2), 32'd0);
    tick();
    chk("r2_ready", 32'(ro2), 32'd1);
    chk("r2_data", rd2, exp);
    idle(1'b1);
    tick();
    chk("r2_after", rd2, 32'h0);
  endtask

  initial begin
    rst    = 1'b1;
    hwdata = 32'h0;
    idle(1'b1);
    repeat (2) tick();
    chk("rst_ready0", 32'(ro0), 32'd1);
    chk("rst_resp0", 32'(rs0), 32'd0);
    chk("rst_data0", rd0, 32'h0);
    chk("rst_ready2", 32'(ro2), 32'd1);
    chk("rst_resp2", 32'(rs2), 32'd0);
    chk("rst_data2", rd2, 32'h0);
    rst = 1'b0;
    tick();

    // back-to-back write then read of the same word
    bus(1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 1'b1);
    tick();
    chk("b2b_wr_ready", 32'(ro0), 32'd1);
    hwdata = 32'hDEADBEEF;
    bus(1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 1'b1);
    tick();
    chk("b2b_rd_ready", 32'(ro0), 32'd1);
    chk("b2b_fwd", rd0, 32'hDEADBEEF);
    idle(1'b1);
    tick();
    chk("b2b_idle_data", rd0, 32'h0);

    // byte, byte, half writes then forwarded word read
    bus(1'b1, 2'b10, 1'b1, 3'd0, 32'h20, 1'b1);
    tick();
    hwdata = 32'h11111111;
    bus(1'b1, 2'b10, 1'b1, 3'd0, 32'h21, 1'b1);
    tick();
    hwdata = 32'h22222222;
    bus(1'b1, 2'b10, 1'b1, 3'd1, 32'h22, 1'b1);
    tick();
    chk("lanes_ready", 32'(ro0), 32'd1);
    hwdata = 32'h44334433;
    bus(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 1'b1);
    tick();
    chk("lanes_fwd", rd0, 32'h44332211);
    idle(1'b1);
    tick();
    bus(1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 1'b1);
    tick();
    chk("lanes_ram", rd0, 32'h44332211);
    idle(1'b1);
    tick();

    // seed 0x30, then misaligned half write must error and not write
    bus(1'b1, 2'b10, 1'b1, 3'd2, 32'h30, 1'b1);
    tick();
    hwdata = 32'hA5A5A5A5;
    idle(1'b1);
    tick();
    bus(1'b1, 2'b10, 1'b1, 3'd1, 32'h31, 1'b1);
    tick();
    chk("err1_ready", 32'(ro0), 32'd0);
    chk("err1_resp", 32'(rs0), 32'd1);
    hwdata = 32'hFFFFFFFF;
    idle(1'b0);
    tick();
    chk("err2_ready", 32'(ro0), 32'd1);
    chk("err2_resp", 32'(rs0), 32'd1);
    chk("err2_data", rd0, 32'h0);
    idle(1'b1);
    tick();
    chk("err_end_resp", 32'(rs0), 32'd0);
    // illegal size and misaligned word also error
    bus(1'b1, 2'b10, 1'b0, 3'd3, 32'h34, 1'b1);
    tick();
    chk("size3_resp", 32'(rs0), 32'd1);
    idle(1'b0);
    tick();
    bus(1'b1, 2'b10, 1'b1, 3'd2, 32'h32, 1'b1);
    tick();
    chk("misw_ready", 32'(ro0), 32'd0);
    chk("misw_resp", 32'(rs0), 32'd1);
    idle(1'b0);
    tick();
    idle(1'b1);
    tick();
    bus(1'b1, 2'b10, 1'b0, 3'd2, 32'h30, 1'b1);
    tick();
    chk("err_nowrite", rd0, 32'hA5A5A5A5);
    idle(1'b1);
    tick();

    // non-accepted cycles leave state and memory alone
    bus(1'b1, 2'b10, 1'b1, 3'd2, 32'h30, 1'b0);
    tick();
    chk("nordy_ready", 32'(ro0), 32'd1);
    chk("nordy_resp", 32'(rs0), 32'd0);
    hwdata = 32'h0BADF00D;
    bus(1'b1, 2'b00, 1'b1, 3'd2, 32'h30, 1'b1);
    tick();
    chk("idle_ready", 32'(ro0), 32'd1);
    bus(1'b1, 2'b01, 1'b1, 3'd2, 32'h30, 1'b1);
    tick();
    chk("busy_ready", 32'(ro0), 32'd1);
    bus(1'b0, 2'b10, 1'b1, 3'd2, 32'h30, 1'b1);
    tick();
    chk("nosel_ready", 32'(ro0), 32'd1);
    idle(1'b1);
    tick();
    bus(1'b1, 2'b10, 1'b0, 3'd2, 32'h30, 1'b1);
    tick();
    chk("noacc_mem", rd0, 32'hA5A5A5A5);
    idle(1'b1);
    repeat (4) tick();

    // two wait states on the second instance
    ws2_write(32'h40, 32'h12345678);
    ws2_read(32'h40, 32'h12345678);

    // reset while a write is waiting must drop it
    ws2_write(32'h50, 32'h01020304);
    bus(1'b1, 2'b10, 1'b1, 3'd2, 32'h50, 1'b1);
    tick();
    chk("rstw_wait", 32'(ro2), 32'd0);
    hwdata = 32'hCAFEF00D;
    idle(1'b0);
    rst = 1'b1;
    tick();
    chk("rstw_ready", 32'(ro2), 32'd1);
    chk("rstw_resp", 32'(rs2), 32'd0);
    chk("rstw_data", rd2, 32'h0);
    rst = 1'b0;
    idle(1'b1);
    repeat (3) tick();
    ws2_read(32'h50, 32'h01020304);
    bus(1'b1, 2'b10, 1'b0, 3'd2, 32'h50, 1'b1);
    tick();
    chk("rstw_mem0", rd0, 32'h01020304);
    idle(1'b1);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
